px_ss_ctrl: RTL and testbench

Configuration master for the pixel subsampler. Accepts an input and target frame resolution and derives per-axis skip parameters with a shared iterative 16-bit divider. It then presents all six parameters atomically on a `px_ss_if` master modport with a one-cycle `apply_stb`. It sits between the register/CSR layer and the subsampler datapath, replacing software-side division.

---
 rtl/px_ss_if.sv | 25 ++
 rtl/px_ss_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_px_ss_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/px_ss_if.sv
// px_ss_if: configuration bundle between px_ss_ctrl (master) and the pixel subsampler (slave).
//   px_to_skip, px_skip_interval, add_px_skip_interval : horizontal skip parameters
//   ln_to_skip, ln_skip_interval, add_ln_skip_interval : vertical skip parameters
//   apply_stb : one-cycle strobe marking the six fields as a freshly applied set
interface px_ss_if;
    logic [15:0] px_to_skip;
    logic [15:0] px_skip_interval;
    logic [15:0] add_px_skip_interval;
    logic [15:0] ln_to_skip;
    logic [15:0] ln_skip_interval;
    logic [15:0] add_ln_skip_interval;
    logic        apply_stb;

    modport master (
        output px_to_skip, px_skip_interval, add_px_skip_interval,
        output ln_to_skip, ln_skip_interval, add_ln_skip_interval,
        output apply_stb
    );

    modport slave (
        input px_to_skip, px_skip_interval, add_px_skip_interval,
        input ln_to_skip, ln_skip_interval, add_ln_skip_interval,
        input apply_stb
    );
endinterface

// File: rtl/px_ss_ctrl.sv
// px_ss_ctrl: derives per-axis subsampling skip parameters from input/target resolution using
// one shared 16-cycle restoring divider, then applies all six fields atomically on ss_if.
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-low reset
//   in_width_i   : source line length      in_height_i  : source frame height
//   out_width_i  : target line length      out_height_i : target frame height
//   cfg_valid_i  : request; accepted when cfg_ready_o is high
//   cfg_ready_o  : idle and able to accept (registered)
//   cfg_err_o    : one-cycle pulse after a rejected request
//   ss_if        : px_ss_if master, fields + apply_stb
module px_ss_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] in_width_i,
    input  logic [15:0] in_height_i,
    input  logic [15:0] out_width_i,
    input  logic [15:0] out_height_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    output logic        cfg_err_o,
    px_ss_if.master     ss_if
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StPxDiv = 2'd1;
    localparam logic [1:0] StLnDiv = 2'd2;
    localparam logic [1:0] StApply = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    // Divider: quo_q starts as the dividend and is shifted into the quotient bit by bit.
    logic [15:0] quo_q, quo_d;
    logic [16:0] rem_q, rem_d;
    logic [15:0] dsr_q, dsr_d;
    // Vertical operands parked until the divider is free.
    logic [15:0] ln_dvd_q, ln_dvd_d;
    logic [15:0] ln_dsr_q, ln_dsr_d;
    // Horizontal results held until APPLY.
    logic [15:0] px_skip_q, px_skip_d;
    logic [15:0] px_int_q, px_int_d;
    logic [15:0] px_add_q, px_add_d;
    // Applied fields.
    logic [15:0] o_px_skip_q, o_px_skip_d;
    logic [15:0] o_px_int_q, o_px_int_d;
    logic [15:0] o_px_add_q, o_px_add_d;
    logic [15:0] o_ln_skip_q, o_ln_skip_d;
    logic [15:0] o_ln_int_q, o_ln_int_d;
    logic [15:0] o_ln_add_q, o_ln_add_d;
    logic        stb_q, stb_d;
    logic        err_q, err_d;
    logic        ready_q, ready_d;

    logic        accept;
    logic        bad_req;
    logic [16:0] rem_sh;
    logic        ge;
    logic [16:0] rem_step;
    logic [15:0] quo_step;
    logic        dsr_zero;

    always_comb begin
        accept  = cfg_valid_i & ready_q;
        bad_req = (in_width_i == 16'd0) || (in_height_i == 16'd0) ||
                  (out_width_i == 16'd0) || (out_height_i == 16'd0) ||
                  (out_width_i > in_width_i) || (out_height_i > in_height_i);

        // One restoring step; remainder stays below the divisor so 17 bits never overflow.
        rem_sh   = {rem_q[15:0], quo_q[15]};
        ge       = rem_sh >= {1'b0, dsr_q};
        rem_step = ge ? (rem_sh - {1'b0, dsr_q}) : rem_sh;
        quo_step = {quo_q[14:0], ge};
        // Zero divisor still runs its 16 steps; the result is discarded.
        dsr_zero = (dsr_q == 16'd0);

        state_d     = state_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dsr_d       = dsr_q;
        ln_dvd_d    = ln_dvd_q;
        ln_dsr_d    = ln_dsr_q;
        px_skip_d   = px_skip_q;
        px_int_d    = px_int_q;
        px_add_d    = px_add_q;
        o_px_skip_d = o_px_skip_q;
        o_px_int_d  = o_px_int_q;
        o_px_add_d  = o_px_add_q;
        o_ln_skip_d = o_ln_skip_q;
        o_ln_int_d  = o_ln_int_q;
        o_ln_add_d  = o_ln_add_q;
        stb_d       = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (bad_req) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = StPxDiv;
                        cnt_d     = 4'd0;
                        quo_d     = in_width_i;
                        rem_d     = 17'd0;
                        dsr_d     = in_width_i - out_width_i;
                        px_skip_d = in_width_i - out_width_i;
                        ln_dvd_d  = in_height_i;
                        ln_dsr_d  = in_height_i - out_height_i;
                    end
                end
            end
            StPxDiv: begin
                quo_d = quo_step;
                rem_d = rem_step;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    px_int_d = dsr_zero ? 16'd0 : quo_step;
                    px_add_d = dsr_zero ? 16'd0 : rem_step[15:0];
                    quo_d    = ln_dvd_q;
                    rem_d    = 17'd0;
                    dsr_d    = ln_dsr_q;
                    cnt_d    = 4'd0;
                    state_d  = StLnDiv;
                end
            end
            StLnDiv: begin
                quo_d = quo_step;
                rem_d = rem_step;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = StApply;
                end
            end
            StApply: begin
                // Vertical result is read straight out of the divider registers.
                o_px_skip_d = px_skip_q;
                o_px_int_d  = px_int_q;
                o_px_add_d  = px_add_q;
                o_ln_skip_d = ln_dsr_q;
                o_ln_int_d  = dsr_zero ? 16'd0 : quo_q;
                o_ln_add_d  = dsr_zero ? 16'd0 : rem_q[15:0];
                stb_d       = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase

        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            quo_q       <= 16'd0;
            rem_q       <= 17'd0;
            dsr_q       <= 16'd0;
            ln_dvd_q    <= 16'd0;
            ln_dsr_q    <= 16'd0;
            px_skip_q   <= 16'd0;
            px_int_q    <= 16'd0;
            px_add_q    <= 16'd0;
            o_px_skip_q <= 16'd0;
            o_px_int_q  <= 16'd0;
            o_px_add_q  <= 16'd0;
            o_ln_skip_q <= 16'd0;
            o_ln_int_q  <= 16'd0;
            o_ln_add_q  <= 16'd0;
            stb_q       <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dsr_q       <= dsr_d;
            ln_dvd_q    <= ln_dvd_d;
            ln_dsr_q    <= ln_dsr_d;
            px_skip_q   <= px_skip_d;
            px_int_q    <= px_int_d;
            px_add_q    <= px_add_d;
            o_px_skip_q <= o_px_skip_d;
            o_px_int_q  <= o_px_int_d;
            o_px_add_q  <= o_px_add_d;
            o_ln_skip_q <= o_ln_skip_d;
            o_ln_int_q  <= o_ln_int_d;
            o_ln_add_q  <= o_ln_add_d;
            stb_q       <= stb_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
        end
    end

    assign cfg_ready_o                = ready_q;
    assign cfg_err_o                  = err_q;
    assign ss_if.px_to_skip           = o_px_skip_q;
    assign ss_if.px_skip_interval     = o_px_int_q;
    assign ss_if.add_px_skip_interval = o_px_add_q;
    assign ss_if.ln_to_skip           = o_ln_skip_q;
    assign ss_if.ln_skip_interval     = o_ln_int_q;
    assign ss_if.add_ln_skip_interval = o_ln_add_q;
    assign ss_if.apply_stb            = stb_q;

endmodule

// File: tb/tb_px_ss_ctrl.sv
module tb_px_ss_ctrl;

    typedef struct packed {
        logic [15:0] pts;
        logic [15:0] psi;
        logic [15:0] apsi;
        logic [15:0] lts;
        logic [15:0] lsi;
        logic [15:0] alsi;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_w, in_h, out_w, out_h;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        cfg_err;

    px_ss_if ss_if ();

    px_ss_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .in_width_i   (in_w),
        .in_height_i  (in_h),
        .out_width_i  (out_w),
        .out_height_i (out_h),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .cfg_err_o    (cfg_err),
        .ss_if        (ss_if)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   err_due  = -1;
    int   prev_acc = -1;
    int   stream_acc = 0;
    bit   stream_on = 1'b0;
    exp_t exp_q[$];
    int   acc_q[$];
    exp_t m_e;
    int   m_a;
    exp_t obs;

    assign obs = {ss_if.px_to_skip, ss_if.px_skip_interval, ss_if.add_px_skip_interval,
                  ss_if.ln_to_skip, ss_if.ln_skip_interval, ss_if.add_ln_skip_interval};

    task automatic chk(input string tag, input logic [95:0] o, input logic [95:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic exp_t model(input logic [15:0] w, h, ow, oh);
        exp_t e;
        e.pts  = w - ow;
        e.psi  = (e.pts == 16'd0) ? 16'd0 : w / e.pts;
        e.apsi = (e.pts == 16'd0) ? 16'd0 : w % e.pts;
        e.lts  = h - oh;
        e.lsi  = (e.lts == 16'd0) ? 16'd0 : h / e.lts;
        e.alsi = (e.lts == 16'd0) ? 16'd0 : h % e.lts;
        return e;
    endfunction

    function automatic bit is_bad(input logic [15:0] w, h, ow, oh);
        return (w == 0) || (h == 0) || (ow == 0) || (oh == 0) || (ow > w) || (oh > h);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: inputs are stable from one edge+1 to the next, so a handshake seen at the
    // falling edge is the accept happening on the coming rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg_valid && cfg_ready) begin
                if (is_bad(in_w, in_h, out_w, out_h)) begin
                    err_due = cyc + 1;
                end else begin
                    exp_q.push_back(model(in_w, in_h, out_w, out_h));
                    acc_q.push_back(cyc + 1);
                    if (stream_on) begin
                        if (prev_acc >= 0) chk("accept_spacing", 96'(cyc + 1 - prev_acc), 96'd34);
                        prev_acc = cyc + 1;
                        stream_acc++;
                    end
                end
            end
            if (cfg_err || err_due == cyc) chk("err_pulse", 96'(cfg_err), 96'(err_due == cyc));
            if (ss_if.apply_stb) begin
                if (exp_q.size() == 0) begin
                    chk("stray_apply", 96'(ss_if.apply_stb), 96'd0);
                end else begin
                    m_e = exp_q.pop_front();
                    m_a = acc_q.pop_front();
                    chk("apply_fields", obs, m_e);
                    chk("apply_latency", 96'(cyc - m_a), 96'd33);
                    chk("ready_at_apply", 96'(cfg_ready), 96'd1);
                end
            end
        end else if (ss_if.apply_stb) begin
            chk("apply_in_reset", 96'(ss_if.apply_stb), 96'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w, h, ow, oh);
        int n = 0;
        while (!cfg_ready && n < 50) begin
            step();
            n++;
        end
        chk("ready_before_req", 96'(cfg_ready), 96'd1);
        in_w = w; in_h = h; out_w = ow; out_h = oh;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", 96'(exp_q.size()), 96'd0);
    endtask

    localparam exp_t P1080 = {16'd640, 16'd3, 16'd0, 16'd360, 16'd3, 16'd0};
    localparam exp_t P1366 = {16'd554, 16'd3, 16'd258, 16'd0, 16'd0, 16'd0};
    localparam exp_t PMAX  = {16'd65534, 16'd1, 16'd1, 16'd1, 16'd2, 16'd0};

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0;
        in_w = 16'd0; in_h = 16'd0; out_w = 16'd0; out_h = 16'd0;
        repeat (3) step();
        chk("rst_fields", obs, 96'd0);
        chk("rst_ready", 96'(cfg_ready), 96'd0);
        chk("rst_err", 96'(cfg_err), 96'd0);
        chk("rst_stb", 96'(ss_if.apply_stb), 96'd0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 96'(cfg_ready), 96'd1);

        send(16'd1920, 16'd1080, 16'd1280, 16'd720);
        chk("busy_ready", 96'(cfg_ready), 96'd0);
        drain(40);
        chk("plan_1080p", obs, P1080);

        send(16'd1920, 16'd1080, 16'd1366, 16'd1080);
        drain(40);
        chk("plan_1366", obs, P1366);

        // Rejected request, then a valid one on the very next edge.
        in_w = 16'd1920; in_h = 16'd1080; out_w = 16'd2000; out_h = 16'd720;
        cfg_valid = 1'b1;
        step();
        chk("err_ready_stays", 96'(cfg_ready), 96'd1);
        chk("fields_after_err", obs, P1366);
        out_w = 16'd1280;
        step();
        cfg_valid = 1'b0;
        chk("busy_after_retry", 96'(cfg_ready), 96'd0);
        drain(40);
        chk("plan_retry", obs, P1080);

        send(16'd0, 16'd1080, 16'd0, 16'd720);
        repeat (3) step();
        chk("zero_dim_hold", obs, P1080);

        send(16'hFFFF, 16'd2, 16'd1, 16'd1);
        drain(40);
        chk("plan_max", obs, PMAX);

        // Reset in the middle of a computation.
        send(16'd1920, 16'd1080, 16'd1280, 16'd720);
        repeat (19) step();
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        step();
        chk("midrst_fields", obs, 96'd0);
        chk("midrst_ready", 96'(cfg_ready), 96'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("midrst_ready_back", 96'(cfg_ready), 96'd1);
        repeat (40) step();
        chk("midrst_no_apply", obs, 96'd0);
        send(16'd1920, 16'd1080, 16'd1366, 16'd1080);
        drain(40);
        chk("plan_after_rst", obs, P1366);

        // Continuous valid with inputs changing every cycle.
        stream_on = 1'b1;
        prev_acc = -1;
        cfg_valid = 1'b1;
        for (int i = 0; i < 140; i++) begin
            in_w  = 16'($urandom_range(1, 65535));
            in_h  = 16'($urandom_range(1, 65535));
            out_w = 16'($urandom_range(1, int'(in_w)));
            out_h = 16'($urandom_range(1, int'(in_h)));
            step();
        end
        cfg_valid = 1'b0;
        stream_on = 1'b0;
        drain(40);
        chk("stream_accepts", 96'(stream_acc), 96'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
